// File: rtl/fifo_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_packer_pkg
//   Shared definitions for the FiFo packer stage.
//   - state_t / FILL / HOLD : two-state controller encoding (legacy-compatible
//                             localparam constants rather than an enum type)
//   - cnt_width()           : width of a counter able to hold 0..pack inclusive
// -----------------------------------------------------------------------------
package fifo_packer_pkg;

    // Controller state encoding.
    typedef logic [0:0] state_t;

    // Accumulating entries popped from the FiFo.
    localparam state_t FILL = 1'b0;
    // Presenting a finished (full or flushed) word, waiting for the handshake.
    localparam state_t HOLD = 1'b1;

    // The counter must represent the value pack itself (a full word), not only
    // the slot indices 0..pack-1, hence the extra bit.
    function automatic int cnt_width(input int pack);
        return $clog2(pack) + 1;
    endfunction

endpackage : fifo_packer_pkg

// File: rtl/fifo_packer.sv
// -----------------------------------------------------------------------------
// fifo_packer
//   Consumer stage for a narrow FiFo. Pops entries through the FiFo's
//   combinational-read interface, packs PACK of them into one wide word and
//   offers that word on a valid/ready port. A flush request closes a partially
//   filled word early and reports how many entries it carries.
//
// Parameters
//   DATA_W : width of one FiFo entry
//   PACK   : entries per output word (>= 2)
//   CNT_W  : derived counter width, holds 0..PACK (not overridable)
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous, active-high reset
//   io_fifo_dout  : FiFo head entry, meaningful while io_fifo_empty is low
//   io_fifo_empty : FiFo empty flag
//   io_fifo_pop   : pop strobe; the head entry is consumed on this edge
//   io_flush      : single-cycle request to emit a partial word
//   io_out_data   : packed word, first popped entry in bits [DATA_W-1:0]
//   io_out_count  : number of valid entries in io_out_data (1..PACK)
//   io_out_valid  : output word valid (registered)
//   io_out_ready  : downstream accepts the word when valid & ready
// -----------------------------------------------------------------------------
module fifo_packer
    import fifo_packer_pkg::*;
#(
    parameter  int DATA_W = 2,
    parameter  int PACK   = 4,
    localparam int CNT_W  = cnt_width(PACK)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        io_fifo_dout,
    input  logic                     io_fifo_empty,
    output logic                     io_fifo_pop,
    input  logic                     io_flush,
    output logic [DATA_W*PACK-1:0]   io_out_data,
    output logic [CNT_W-1:0]         io_out_count,
    output logic                     io_out_valid,
    input  logic                     io_out_ready
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

    // Controller state and its next-state values.
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_nxt_s;
    logic [CNT_W-1:0]        count_inc_s;
    logic [CNT_W-1:0]        out_count_r;
    logic [CNT_W-1:0]        out_count_nxt_s;
    logic                    valid_r;
    logic                    valid_nxt_s;

    // Datapath control.
    logic                    pop_s;
    logic                    acc_clear_s;
    logic [PACK-1:0]         slot_we_s;
    logic [DATA_W*PACK-1:0]  acc_s;

    // A pop is only offered while filling; reset blocks it so no entry is
    // consumed and then thrown away by the reset in the same cycle.
    assign pop_s = (state_r == FILL) & ~io_fifo_empty & ~reset;

    // Entry count after this cycle's pop (if any). Used both for the full-word
    // test and for the flush test, so a flush includes a same-cycle pop.
    assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, pop_s};

    // Next-state, counter and output-register decode for the two-state controller.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        out_count_nxt_s = out_count_r;
        valid_nxt_s     = valid_r;
        acc_clear_s     = 1'b0;
        case (state_r)
            FILL: begin
                count_nxt_s = count_inc_s;
                if (count_inc_s == CNT_FULL) begin
                    // Full word: forced hand-over, the counter can never pass PACK.
                    state_nxt_s     = HOLD;
                    out_count_nxt_s = CNT_FULL;
                    valid_nxt_s     = 1'b1;
                end else if (io_flush && (count_inc_s != CNT_ZERO)) begin
                    state_nxt_s     = HOLD;
                    out_count_nxt_s = count_inc_s;
                    valid_nxt_s     = 1'b1;
                end else begin
                    // Keep filling; a flush with nothing accumulated is dropped.
                    state_nxt_s     = FILL;
                    out_count_nxt_s = out_count_r;
                    valid_nxt_s     = 1'b0;
                end
            end
            HOLD: begin
                if (io_out_ready) begin
                    // Handshake: start the next word from slot 0 with a clean
                    // accumulator so a short word never carries stale bits.
                    state_nxt_s     = FILL;
                    count_nxt_s     = CNT_ZERO;
                    out_count_nxt_s = CNT_ZERO;
                    valid_nxt_s     = 1'b0;
                    acc_clear_s     = 1'b1;
                end else begin
                    // Word and count stay frozen; flush is ignored here.
                    state_nxt_s     = HOLD;
                    count_nxt_s     = count_r;
                    out_count_nxt_s = out_count_r;
                    valid_nxt_s     = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover to an empty FILL.
                state_nxt_s     = FILL;
                count_nxt_s     = CNT_ZERO;
                out_count_nxt_s = CNT_ZERO;
                valid_nxt_s     = 1'b0;
                acc_clear_s     = 1'b1;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= FILL;
            count_r     <= CNT_ZERO;
            out_count_r <= CNT_ZERO;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            out_count_r <= out_count_nxt_s;
            valid_r     <= valid_nxt_s;
        end
    end

    // Accumulator: one register per slot, written only when the pop lands on
    // that slot index. pop_s is already zero outside FILL, so slots are frozen
    // while the word is being held.
    for (genvar g = 0; g < PACK; g++) begin : g_slot
        logic [DATA_W-1:0] slot_r;

        assign slot_we_s[g] = pop_s & (count_r == CNT_W'(g));

        // Per-slot storage with reset, post-handshake clear and pop write.
        always_ff @(posedge clk) begin
            if (reset) begin
                slot_r <= {DATA_W{1'b0}};
            end else if (acc_clear_s) begin
                slot_r <= {DATA_W{1'b0}};
            end else if (slot_we_s[g]) begin
                slot_r <= io_fifo_dout;
            end else begin
                slot_r <= slot_r;
            end
        end

        assign acc_s[g*DATA_W +: DATA_W] = slot_r;
    end

    // All outputs except the pop strobe come straight from flops.
    assign io_fifo_pop  = pop_s;
    assign io_out_data  = acc_s;
    assign io_out_count = out_count_r;
    assign io_out_valid = valid_r;

endmodule : fifo_packer

// File: tb/tb_fifo_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_packer
//   Directed bench for fifo_packer (DATA_W=2, PACK=4). A small FiFo model feeds
//   the DUT; every expected output word is queued when its stimulus is issued
//   and a monitor thread compares it at the valid/ready handshake. Inputs are
//   driven 2 time units after the rising edge; everything is sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_packer;

    logic       clk;
    logic       reset;
    logic [1:0] io_fifo_dout;
    logic       io_fifo_empty;
    logic       io_fifo_pop;
    logic       io_flush;
    logic [7:0] io_out_data;
    logic [2:0] io_out_count;
    logic       io_out_valid;
    logic       io_out_ready;

    fifo_packer #(
        .DATA_W (2),
        .PACK   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_fifo_dout  (io_fifo_dout),
        .io_fifo_empty (io_fifo_empty),
        .io_fifo_pop   (io_fifo_pop),
        .io_flush      (io_flush),
        .io_out_data   (io_out_data),
        .io_out_count  (io_out_count),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready)
    );

    // Clock generator.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FiFo model: pushes come from the stimulus, pops from the DUT strobe.
    logic [1:0] fifo_mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr = 8'd0;

    assign io_fifo_empty = (wr_ptr == rd_ptr);
    assign io_fifo_dout  = fifo_mem[rd_ptr];

    // FiFo read pointer advances on every accepted pop.
    always @(posedge clk) begin
        if (io_fifo_pop) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] count;
    } word_t;

    word_t exp_q[$];
    int    checks;
    int    errors;
    int    words_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [2:0] c);
        word_t w;
        w.data  = d;
        w.count = c;
        exp_q.push_back(w);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // Starts at a drive point, ends at a falling edge with valid high (or a FAIL).
    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        settle();
        while (!io_out_valid && n < budget) begin
            next();
            settle();
            n++;
        end
        chk("wait_valid", 32'(io_out_valid), 32'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        words_seen = 0;
        wr_ptr     = 8'd0;
        for (int i = 0; i < 256; i++) begin
            fifo_mem[i] = 2'd0;
        end
        reset        = 1'b1;
        io_flush     = 1'b0;
        io_out_ready = 1'b0;

        // Scoreboard monitor: compares every accepted word with the queue head.
        fork
            begin : monitor
                word_t e;
                forever begin
                    @(negedge clk);
                    if (!reset && io_out_valid && io_out_ready) begin
                        words_seen++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL out_word: unexpected word data=%h count=%0d",
                                     io_out_data, io_out_count);
                        end else begin
                            e = exp_q.pop_front();
                            if (io_out_data !== e.data || io_out_count !== e.count) begin
                                errors++;
                                $display("FAIL out_word: got data=%h count=%0d expected data=%h count=%0d",
                                         io_out_data, io_out_count, e.data, e.count);
                            end
                        end
                    end
                end
            end
        join_none

        // ---- reset state; FiFo loaded so a pop during reset would be visible
        next();
        next();
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        settle();
        chk("reset_valid", 32'(io_out_valid), 32'd0);
        chk("reset_count", 32'(io_out_count), 32'd0);
        chk("reset_data",  32'(io_out_data),  32'h00);
        chk("reset_pop",   32'(io_fifo_pop),  32'd0);

        // ---- 1,2,3,0 with ready high: four back-to-back pops, then 8'h39
        next();
        reset        = 1'b0;
        io_out_ready = 1'b1;
        expect_word(8'h39, 3'd4);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t1_pop", 32'(io_fifo_pop), 32'd1);
            chk("t1_valid_low", 32'(io_out_valid), 32'd0);
            next();
        end
        settle();
        chk("t1_valid", 32'(io_out_valid), 32'd1);
        chk("t1_count", 32'(io_out_count), 32'd4);
        chk("t1_data",  32'(io_out_data),  32'h39);
        chk("t1_hold_pop", 32'(io_fifo_pop), 32'd0);
        next();
        io_out_ready = 1'b0;
        push(2'd3); push(2'd1);
        expect_word(8'h39, 3'd4);
        settle();
        chk("t1_valid_drop", 32'(io_out_valid), 32'd0);
        chk("t1_pop_resume", 32'(io_fifo_pop), 32'd1);

        // ---- same stream, ready low for 5 HOLD cycles
        next();
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(io_out_valid), 32'd1);
            chk("t2_hold_pop",   32'(io_fifo_pop),  32'd0);
            chk("t2_hold_data",  32'(io_out_data),  32'h39);
            next();
            settle();
        end
        chk("t2_no_early_word", 32'(words_seen), 32'd1);
        next();
        io_out_ready = 1'b1;
        settle();
        next();
        io_out_ready = 1'b0;
        next();
        next();
        chk("t2_one_word", 32'(words_seen), 32'd2);

        // ---- pop 3,1 then flush with FiFo empty: 8'h07, count 2
        io_flush = 1'b1;
        expect_word(8'h07, 3'd2);
        next();
        io_flush = 1'b0;
        settle();
        chk("t3_valid", 32'(io_out_valid), 32'd1);
        chk("t3_count", 32'(io_out_count), 32'd2);
        chk("t3_data",  32'(io_out_data),  32'h07);
        next();
        io_flush = 1'b1;
        next();
        io_flush = 1'b0;
        settle();
        chk("t3_hold_valid", 32'(io_out_valid), 32'd1);
        chk("t3_hold_count", 32'(io_out_count), 32'd2);
        chk("t3_hold_data",  32'(io_out_data),  32'h07);
        next();
        io_out_ready = 1'b1;
        settle();
        next();

        // ---- flush together with the third pop (2,2,1): 8'h1A, count 3
        io_out_ready = 1'b0;
        push(2'd2); push(2'd2); push(2'd1);
        next();
        next();
        io_flush = 1'b1;
        expect_word(8'h1A, 3'd3);
        next();
        io_flush = 1'b0;
        settle();
        chk("t4_valid", 32'(io_out_valid), 32'd1);
        chk("t4_count", 32'(io_out_count), 32'd3);
        chk("t4_data",  32'(io_out_data),  32'h1A);
        next();
        io_out_ready = 1'b1;
        settle();
        next();
        io_out_ready = 1'b0;
        // flush with nothing accumulated and FiFo empty: ignored
        io_flush = 1'b1;
        next();
        io_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_empty_flush_valid", 32'(io_out_valid), 32'd0);
            next();
        end

        // ---- one entry, then FiFo empty for 10 cycles, then resume
        push(2'd2);
        settle();
        chk("t5_first_pop", 32'(io_fifo_pop), 32'd1);
        next();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t5_starve_pop",   32'(io_fifo_pop),  32'd0);
            chk("t5_starve_valid", 32'(io_out_valid), 32'd0);
            next();
        end
        push(2'd3); push(2'd1); push(2'd0);
        expect_word(8'h1E, 3'd4);
        wait_valid(10);
        chk("t5_count", 32'(io_out_count), 32'd4);
        next();
        io_out_ready = 1'b1;
        settle();
        next();
        io_out_ready = 1'b0;

        // ---- reset after two pops, then reset while holding a word
        push(2'd1); push(2'd1); push(2'd3); push(2'd0); push(2'd2); push(2'd1);
        next();
        next();
        reset = 1'b1;
        settle();
        chk("t6_reset_pop", 32'(io_fifo_pop), 32'd0);
        next();
        reset = 1'b0;
        settle();
        chk("t6_after_reset_valid", 32'(io_out_valid), 32'd0);
        chk("t6_after_reset_count", 32'(io_out_count), 32'd0);
        chk("t6_after_reset_data",  32'(io_out_data),  32'h00);
        chk("t6_after_reset_pop",   32'(io_fifo_pop),  32'd1);
        next();
        wait_valid(10);
        chk("t6_word_from_slot0", 32'(io_out_data), 32'h63);
        next();
        push(2'd2); push(2'd3); push(2'd0); push(2'd1);
        reset = 1'b1;
        settle();
        chk("t6_hold_reset_pop", 32'(io_fifo_pop), 32'd0);
        next();
        reset = 1'b0;
        settle();
        chk("t6_hold_reset_valid", 32'(io_out_valid), 32'd0);
        chk("t6_hold_reset_count", 32'(io_out_count), 32'd0);
        chk("t6_hold_reset_data",  32'(io_out_data),  32'h00);
        chk("t6_hold_reset_pop",   32'(io_fifo_pop),  32'd1);
        expect_word(8'h4E, 3'd4);
        next();
        io_out_ready = 1'b1;

        // ---- drain the scoreboard within a bounded number of cycles
        begin
            int n;
            n = 0;
            settle();
            while (exp_q.size() != 0 && n < 30) begin
                next();
                settle();
                n++;
            end
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("word_total", 32'(words_seen), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_packer
